alarm_controller: RTL and testbench

//  Top-level alarm sequencer. Owns the system FSM (IDLE/SET/TRIGGER/ALERT), the
//  4-digit passcode tracker and the seconds countdown. Drives the system_state,

---
 rtl/alarm_pkg.sv | 31 +++
 rtl/passcode_checker.sv | 31 +++
 rtl/alarm_controller.sv | 106 ++++++++++
 tb/tb_alarm_controller.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and passcode constants for the alarm controller and display block.
package alarm_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'd0,
    STATE_SET     = 2'd1,
    STATE_TRIGGER = 2'd2,
    STATE_ALERT   = 2'd3
  } fsm_state_t;

  // Passcode progress: number of correct digits entered so far.
  localparam logic [2:0] sIdle     = 3'd0;
  localparam logic [2:0] sDig1Corr = 3'd1;
  localparam logic [2:0] sDig2Corr = 3'd2;
  localparam logic [2:0] sDig3Corr = 3'd3;
  localparam logic [2:0] sDig4Corr = 3'd4;

  // Expected BCD digit at position idx; digit 0 is the most significant nibble.
  function automatic logic [3:0] code_nibble(input logic [15:0] code,
                                             input logic [2:0]  idx);
    logic [3:0] n;
    case (idx)
      3'd0:    n = code[15:12];
      3'd1:    n = code[11:8];
      3'd2:    n = code[7:4];
      default: n = code[3:0];
    endcase
    return n;
  endfunction

endpackage

// File: rtl/passcode_checker.sv
// Tracks how many consecutive correct passcode digits have been entered.
module passcode_checker
  import alarm_pkg::*;
#(
  parameter logic [15:0] PASSCODE = 16'h1234
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       clear,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  output logic [2:0] passcode_state,
  output logic       match
);

  assign match = (passcode_state == sDig4Corr);

  // sDig4Corr lasts one cycle and swallows any digit offered during it;
  // a wrong digit returns to sIdle without counting as a new first digit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      passcode_state <= sIdle;
    else if (clear || match)
      passcode_state <= sIdle;
    else if (enable && digit_valid)
      passcode_state <= (digit == code_nibble(PASSCODE, passcode_state))
                        ? passcode_state + 3'd1 : sIdle;
  end

endmodule

// File: rtl/alarm_controller.sv
// System sequencer: IDLE/SET/TRIGGER/ALERT FSM, passcode disarm, 1 Hz countdown.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int unsigned  TICK_DIV    = 50_000_000,
  parameter int unsigned  COUNTDOWN_S = 30,
  parameter logic [15:0]  PASSCODE    = 16'h1234
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       arm,
  input  logic       sensor,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  output fsm_state_t system_state,
  output logic [2:0] passcode_state,
  output logic [7:0] timer,
  output logic       alarm
);

  localparam int         PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [7:0] TIMER_INIT = 8'(COUNTDOWN_S);

  fsm_state_t    state_d;
  logic          alarm_d;
  logic [PW-1:0] prescaler;
  logic          match;
  logic          expiry;

  // Last second elapsing while counting down.
  assign expiry = (system_state == STATE_TRIGGER) && (prescaler == PRE_MAX) &&
                  (timer == 8'd1);

  passcode_checker #(.PASSCODE(PASSCODE)) u_passcode (
    .clock          (clock),
    .reset          (reset),
    .enable         (system_state != STATE_IDLE),
    .clear          (state_d == STATE_IDLE),
    .digit_valid    (digit_valid),
    .digit          (digit),
    .passcode_state (passcode_state),
    .match          (match)
  );

  // State and alarm registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      system_state <= STATE_IDLE;
      alarm        <= 1'b0;
    end else begin
      system_state <= state_d;
      alarm        <= alarm_d;
    end
  end

  // Next state; disarm beats expiry beats sensor trip.
  always_comb begin
    state_d = system_state;
    case (system_state)
      STATE_IDLE:    if (arm) state_d = STATE_SET;
      STATE_SET:     if (match) state_d = STATE_IDLE;
                     else if (sensor) state_d = STATE_TRIGGER;
      STATE_TRIGGER: if (match) state_d = STATE_IDLE;
                     else if (expiry) state_d = STATE_ALERT;
      STATE_ALERT:   if (match) state_d = STATE_IDLE;
      default:       state_d = STATE_IDLE;
    endcase
  end

  // Output decode, registered alongside the state.
  always_comb begin
    alarm_d = (state_d == STATE_ALERT);
  end

  // Prescaler and countdown; only advance while staying in TRIGGER.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      timer     <= TIMER_INIT;
    end else begin
      case (state_d)
        STATE_TRIGGER: begin
          if (system_state != STATE_TRIGGER) begin
            prescaler <= '0;
            timer     <= TIMER_INIT;
          end else if (prescaler == PRE_MAX) begin
            prescaler <= '0;
            if (timer != 8'd0) timer <= timer - 8'd1;
          end else begin
            prescaler <= prescaler + PW'(1);
          end
        end
        STATE_ALERT: begin
          prescaler <= '0;
          timer     <= 8'd0;
        end
        default: begin
          prescaler <= '0;
          timer     <= TIMER_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller (TICK_DIV=10, COUNTDOWN_S=3, code 1234).
module tb_alarm_controller;
  import alarm_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       arm = 1'b0;
  logic       sensor = 1'b0;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  fsm_state_t system_state;
  logic [2:0] passcode_state;
  logic [7:0] timer;
  logic       alarm;

  int passed = 0;
  int total  = 0;

  alarm_controller #(.TICK_DIV(10), .COUNTDOWN_S(3), .PASSCODE(16'h1234)) dut (
    .clock          (clock),
    .reset          (reset),
    .arm            (arm),
    .sensor         (sensor),
    .digit_valid    (digit_valid),
    .digit          (digit),
    .system_state   (system_state),
    .passcode_state (passcode_state),
    .timer          (timer),
    .alarm          (alarm)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input int st, input int pc,
                         input int tm, input int al);
    check({tag, ".state"}, int'(system_state), st);
    check({tag, ".pc"}, int'(passcode_state), pc);
    check({tag, ".timer"}, int'(timer), tm);
    check({tag, ".alarm"}, int'(alarm), al);
  endtask

  // Inputs change 1 ns after a rising edge and are sampled at the next one.
  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_arm();
    arm = 1'b1; step(); arm = 1'b0;
  endtask

  task automatic trip();
    sensor = 1'b1; step(); sensor = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    digit_valid = 1'b1; digit = d; step(); digit_valid = 1'b0;
  endtask

  int seq_d [10] = '{1, 2, 9, 1, 2, 1, 1, 2, 3, 4};
  int seq_p [10] = '{1, 2, 0, 1, 2, 0, 1, 2, 3, 4};

  initial begin
    // 1: reset values, arm
    ticks(2);
    chk_all("rst", STATE_IDLE, 0, 3, 0);
    reset = 1'b0;
    step();
    key(4'd1);
    check("idle_digit_ignored", int'(passcode_state), 0);
    sensor = 1'b1; step(); sensor = 1'b0;
    check("idle_sensor_ignored", int'(system_state), STATE_IDLE);
    pulse_arm();
    chk_all("arm", STATE_SET, 0, 3, 0);
    pulse_arm();
    check("set_arm_ignored", int'(system_state), STATE_SET);

    // 2: countdown to ALERT
    trip();
    chk_all("trig_entry", STATE_TRIGGER, 0, 3, 0);
    ticks(9);
    check("trig_e9", int'(timer), 3);
    step();
    check("trig_e10", int'(timer), 2);
    ticks(10);
    check("trig_e20", int'(timer), 1);
    ticks(9);
    chk_all("trig_e29", STATE_TRIGGER, 0, 1, 0);
    step();
    chk_all("alert", STATE_ALERT, 0, 0, 1);
    pulse_arm();
    chk_all("alert_arm_ignored", STATE_ALERT, 0, 0, 1);
    ticks(15);
    check("alert_timer_held", int'(timer), 0);

    // disarm from ALERT
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    chk_all("alert_d4", STATE_ALERT, 4, 0, 1);
    step();
    chk_all("alert_disarm", STATE_IDLE, 0, 3, 0);

    // 3: disarm from TRIGGER; digit during sDig4Corr is swallowed
    pulse_arm(); trip();
    key(4'd1); check("trg_d1", int'(passcode_state), 1);
    key(4'd2); check("trg_d2", int'(passcode_state), 2);
    key(4'd3); check("trg_d3", int'(passcode_state), 3);
    digit_valid = 1'b1; digit = 4'd4; step();
    chk_all("trg_d4", STATE_TRIGGER, 4, 3, 0);
    digit = 4'd1; step(); digit_valid = 1'b0;
    chk_all("trg_disarm", STATE_IDLE, 0, 3, 0);

    // 4: wrong digits in SET, including a gap cycle
    pulse_arm();
    for (int i = 0; i < 10; i++) begin
      key(4'(seq_d[i]));
      check($sformatf("set_seq%0d", i), int'(passcode_state), seq_p[i]);
      if (i == 1) begin
        step();
        check("set_gap_hold", int'(passcode_state), 2);
      end
    end
    step();
    chk_all("set_disarm", STATE_IDLE, 0, 3, 0);

    // 4th digit with sensor in SET: one TRIGGER cycle then IDLE
    pulse_arm();
    key(4'd1); key(4'd2); key(4'd3);
    digit_valid = 1'b1; digit = 4'd4; sensor = 1'b1; step();
    digit_valid = 1'b0; sensor = 1'b0;
    chk_all("d4_sensor", STATE_TRIGGER, 4, 3, 0);
    step();
    chk_all("d4_sensor_idle", STATE_IDLE, 0, 3, 0);

    // 5: async reset in ALERT between digits 2 and 3
    pulse_arm(); trip(); ticks(30);
    check("r_alert", int'(alarm), 1);
    key(4'd1); key(4'd2);
    check("r_pc2", int'(passcode_state), 2);
    #2 reset = 1'b1;
    #1 chk_all("r_async", STATE_IDLE, 0, 3, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("r_post_alarm%0d", i), int'(alarm), 0);
    end
    check("r_post_state", int'(system_state), STATE_IDLE);

    // 6: disarm coincides with expiry: IDLE wins, alarm never set
    pulse_arm(); trip();
    ticks(20);
    check("x_e20", int'(timer), 1);
    ticks(5);
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    chk_all("x_e29", STATE_TRIGGER, 4, 1, 0);
    step();
    chk_all("x_e30", STATE_IDLE, 0, 3, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("x_post_alarm%0d", i), int'(alarm), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
